ddr4_phy_xiphy_tri_oe_gen: RTL and testbench

- Upstream feeder for the XIPHY tristate bitslice. Turns fabric write commands into the 8-bit per-fabric-cycle tristate pattern that the bitslice control places on the tristate serializer data field of the ribbon cable.
- Fabric clock to DRAM is 4:1, so 8 UI per fabric cycle.
- Adds write preamble and postamble around each burst and merges back-to-back windows.
- Flags commands whose data bursts collide.

---
 rtl/ddr4_phy_xiphy_tri_oe_gen.sv | 83 ++++++++
 tb/tb_ddr4_phy_xiphy_tri_oe_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ddr4_phy_xiphy_tri_oe_gen.sv
// Tristate pattern generator: expands write commands into 8-UI-per-cycle drive/data masks with pre/postamble.
// Latency: 1 fabric cycle from command sample to data UI 0 on tri_q/data_valid_q; preamble may appear at the sample edge.
// Backpressure: none; one command accepted per cycle, colliding bursts are merged and flagged in err_overlap.
module ddr4_phy_xiphy_tri_oe_gen #(
  parameter int       PRE_UI   = 2,
  parameter int       POST_UI  = 1,
  parameter int       BURST_UI = 8,
  parameter bit       INIT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_offset,
  input  logic       force_tri,
  output logic [7:0] tri_q,
  output logic       wr_active,
  output logic [7:0] data_valid_q,
  output logic       err_overlap
);

  // Reject parameter combinations the window arithmetic cannot represent.
  if (PRE_UI < 0 || PRE_UI > 4) begin : g_bad_pre
    $fatal(1, "PRE_UI must be in 0..4");
  end
  if (POST_UI < 0 || POST_UI > 4) begin : g_bad_post
    $fatal(1, "POST_UI must be in 0..4");
  end
  if (BURST_UI != 4 && BURST_UI != 8) begin : g_bad_burst
    $fatal(1, "BURST_UI must be 4 or 8");
  end

  // Contiguous run of ones as wide as the full drive window and the data burst.
  localparam int          WIN_UI  = PRE_UI + BURST_UI + POST_UI;
  localparam logic [31:0] MW_BASE = (32'h1 << WIN_UI) - 32'h1;
  localparam logic [31:0] MD_BASE = (32'h1 << BURST_UI) - 32'h1;

  logic [31:0] p_q, p_d;
  logic [31:0] d_q, d_d;
  logic [31:0] mw, md;
  logic [31:0] pn, dn;
  logic [7:0]  tri_d;
  logic [7:0]  data_valid_d;
  logic        err_q, err_d;

  // Place the command windows relative to the current output cycle, then merge into the pending state.
  always_comb begin
    mw           = '0;
    md           = '0;
    if (wr_en) begin
      mw = MW_BASE << (8 - PRE_UI + int'(wr_offset));
      md = MD_BASE << (8 + int'(wr_offset));
    end
    pn           = p_q | mw;
    dn           = d_q | md;
    tri_d        = force_tri ? 8'hFF : ~pn[7:0];
    data_valid_d = dn[7:0];
    p_d          = pn >> 8;
    d_d          = dn >> 8;
    err_d        = err_q | ((d_q & md) != 32'h0);
  end

  // Emit the current 8 UIs and advance the pending windows by one fabric cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q          <= '0;
      d_q          <= '0;
      tri_q        <= {8{INIT}};
      data_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      tri_q        <= tri_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  // Busy while any drive UI is still pending or on the output right now (force_tri does not hide it).
  assign wr_active   = (|p_q) | (tri_q != 8'hFF);
  assign err_overlap = err_q;

endmodule

// File: tb/tb_ddr4_phy_xiphy_tri_oe_gen.sv
module tb_ddr4_phy_xiphy_tri_oe_gen;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_offset;
  logic       force_tri;
  logic [7:0] tri_q;
  logic       wr_active;
  logic [7:0] data_valid_q;
  logic       err_overlap;

  int checks;
  int errors;

  ddr4_phy_xiphy_tri_oe_gen dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_offset    (wr_offset),
    .force_tri    (force_tri),
    .tri_q        (tri_q),
    .wr_active    (wr_active),
    .data_valid_q (data_valid_q),
    .err_overlap  (err_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    wr_offset = 3'd0;
    force_tri = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    wr_offset = 3'd0;
    force_tri = 1'b0;
    #12;
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL reset_tri got %h exp %h", tri_q, 8'hFF); end
    checks++; if (data_valid_q !== 8'h00) begin errors++; $display("FAIL reset_dv got %h exp %h", data_valid_q, 8'h00); end
    checks++; if (wr_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", wr_active); end
    checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_overlap); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_aligned();
    wr_en = 1'b1; wr_offset = 3'd0;
    tick();  // edge N
    wr_en = 1'b0;
    checks++; if (tri_q !== 8'h3F) begin errors++; $display("FAIL aligned_n_tri got %h exp %h", tri_q, 8'h3F); end
    checks++; if (wr_active !== 1'b1) begin errors++; $display("FAIL aligned_n_active got %b exp 1", wr_active); end
    tick();  // N+1
    checks++; if (tri_q !== 8'h00) begin errors++; $display("FAIL aligned_n1_tri got %h exp %h", tri_q, 8'h00); end
    checks++; if (data_valid_q !== 8'hFF) begin errors++; $display("FAIL aligned_n1_dv got %h exp %h", data_valid_q, 8'hFF); end
    tick();  // N+2
    checks++; if (tri_q !== 8'hFE) begin errors++; $display("FAIL aligned_n2_tri got %h exp %h", tri_q, 8'hFE); end
    checks++; if (data_valid_q !== 8'h00) begin errors++; $display("FAIL aligned_n2_dv got %h exp %h", data_valid_q, 8'h00); end
    checks++; if (wr_active !== 1'b1) begin errors++; $display("FAIL aligned_n2_active got %b exp 1", wr_active); end
    tick();  // N+3
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL aligned_n3_tri got %h exp %h", tri_q, 8'hFF); end
    checks++; if (wr_active !== 1'b0) begin errors++; $display("FAIL aligned_n3_active got %b exp 0", wr_active); end
    idle(2);
  endtask

  task automatic test_offset();
    wr_en = 1'b1; wr_offset = 3'd5;
    tick();  // N
    wr_en = 1'b0; wr_offset = 3'd0;
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL offset_n_tri got %h exp %h", tri_q, 8'hFF); end
    tick();  // N+1
    checks++; if (tri_q !== 8'h07) begin errors++; $display("FAIL offset_n1_tri got %h exp %h", tri_q, 8'h07); end
    checks++; if (data_valid_q !== 8'hE0) begin errors++; $display("FAIL offset_n1_dv got %h exp %h", data_valid_q, 8'hE0); end
    tick();  // N+2
    checks++; if (tri_q !== 8'hC0) begin errors++; $display("FAIL offset_n2_tri got %h exp %h", tri_q, 8'hC0); end
    checks++; if (data_valid_q !== 8'h1F) begin errors++; $display("FAIL offset_n2_dv got %h exp %h", data_valid_q, 8'h1F); end
    tick();  // N+3
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL offset_n3_tri got %h exp %h", tri_q, 8'hFF); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tri [0:4];
    logic [7:0] exp_dv  [0:4];
    exp_tri[0] = 8'h3F; exp_dv[0] = 8'h00;
    exp_tri[1] = 8'h00; exp_dv[1] = 8'hFF;
    exp_tri[2] = 8'h00; exp_dv[2] = 8'hFF;
    exp_tri[3] = 8'hFE; exp_dv[3] = 8'h00;
    exp_tri[4] = 8'hFF; exp_dv[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      wr_en = (i < 2); wr_offset = 3'd0;
      tick();
      checks++; if (tri_q !== exp_tri[i]) begin errors++; $display("FAIL b2b_tri[%0d] got %h exp %h", i, tri_q, exp_tri[i]); end
      checks++; if (data_valid_q !== exp_dv[i]) begin errors++; $display("FAIL b2b_dv[%0d] got %h exp %h", i, data_valid_q, exp_dv[i]); end
      checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d] got %b exp 0", i, err_overlap); end
    end
    idle(2);
  endtask

  task automatic test_force_tri();
    wr_en = 1'b1; wr_offset = 3'd0;
    tick();  // N
    wr_en = 1'b0;
    force_tri = 1'b1;
    checks++; if (tri_q !== 8'h3F) begin errors++; $display("FAIL force_n_tri got %h exp %h", tri_q, 8'h3F); end
    tick();  // N+1 under force
    force_tri = 1'b0;
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL force_n1_tri got %h exp %h", tri_q, 8'hFF); end
    checks++; if (data_valid_q !== 8'hFF) begin errors++; $display("FAIL force_n1_dv got %h exp %h", data_valid_q, 8'hFF); end
    checks++; if (wr_active !== 1'b1) begin errors++; $display("FAIL force_n1_active got %b exp 1", wr_active); end
    tick();  // N+2 released
    checks++; if (tri_q !== 8'hFE) begin errors++; $display("FAIL force_n2_tri got %h exp %h", tri_q, 8'hFE); end
    tick();
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL force_n3_tri got %h exp %h", tri_q, 8'hFF); end
    idle(2);
  endtask

  // o=4 leaves data pending in the next window (UIs 8..11); an o=0 write right after claims those UIs.
  task automatic test_collision();
    wr_en = 1'b1; wr_offset = 3'd4;
    tick();  // N
    checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL coll_n_err got %b exp 0", err_overlap); end
    wr_offset = 3'd0;
    tick();  // N+1
    wr_en = 1'b0;
    checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL coll_n1_err got %b exp 1", err_overlap); end
    checks++; if (data_valid_q !== 8'hF0) begin errors++; $display("FAIL coll_n1_dv got %h exp %h", data_valid_q, 8'hF0); end
    tick();  // N+2: first burst tail 0..3 merged with second burst 0..7
    checks++; if (data_valid_q !== 8'hFF) begin errors++; $display("FAIL coll_n2_dv got %h exp %h", data_valid_q, 8'hFF); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL coll_sticky[%0d] got %b exp 1", i, err_overlap); end
    end
  endtask

  task automatic test_reset_mid_burst();
    wr_en = 1'b1; wr_offset = 3'd0;
    tick();  // N
    wr_en = 1'b0;
    tick();  // N+1, data on the wire
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL rstmid_tri got %h exp %h", tri_q, 8'hFF); end
    checks++; if (data_valid_q !== 8'h00) begin errors++; $display("FAIL rstmid_dv got %h exp %h", data_valid_q, 8'h00); end
    checks++; if (wr_active !== 1'b0) begin errors++; $display("FAIL rstmid_active got %b exp 0", wr_active); end
    checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", err_overlap); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (tri_q !== 8'hFF) begin errors++; $display("FAIL rstmid_post_tri[%0d] got %h exp %h", i, tri_q, 8'hFF); end
      checks++; if (wr_active !== 1'b0) begin errors++; $display("FAIL rstmid_post_active[%0d] got %b exp 0", i, wr_active); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_aligned();
    test_offset();
    test_back_to_back();
    test_force_tri();
    test_collision();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
